// File: rtl/mem_lsu.sv
// mem_lsu: load/store requester for the byte-addressed data memory.
// Accepts one load or store at a time (valid/ready), performs a single
// ACCESS cycle against a memory with combinational read, and returns an
// extended load result or an error response.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid / req_ready    request handshake (ready only in IDLE)
//   req_we, req_funct3       store flag and access size/extension
//   req_addr, req_wdata      byte address, low-aligned store data
//   resp_valid / resp_ready  response handshake
//   resp_rdata, resp_err     extended load data (0 for stores/errors), error flag
//   mem_we, mem_addr         byte write enables, memory byte address
//   mem_wdata, mem_rdata     memory write data, combinational read data
module mem_lsu #(
   parameter int unsigned ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic [3:0]        mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t      state;
   logic        we_q;
   logic [2:0]  funct3_q;
   logic [3:0]  mem_we_q;

   logic        size_bad_c;
   logic        range_bad_c;
   logic        align_bad_c;
   logic        req_err_c;
   logic [3:0]  be_c;
   logic [31:0] wdata_mask_c;
   logic [31:0] load_ext_c;

   // Request legality, evaluated on the live request while in IDLE
   always_comb begin
      size_bad_c  = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
      range_bad_c = (req_addr >> ADDR_W) != 32'd0;
      align_bad_c = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                    ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
      req_err_c   = size_bad_c || range_bad_c || align_bad_c;
   end

   // Store byte enables and write data with bytes above the size cleared
   always_comb begin
      be_c         = 4'b1111;
      wdata_mask_c = req_wdata;
      case (req_funct3[1:0])
         2'b00: begin
            be_c         = 4'b0001;
            wdata_mask_c = {24'd0, req_wdata[7:0]};
         end
         2'b01: begin
            be_c         = 4'b0011;
            wdata_mask_c = {16'd0, req_wdata[15:0]};
         end
         default: ;
      endcase
   end

   // Sign/zero extension of the memory read for the latched load size
   always_comb begin
      load_ext_c = mem_rdata;
      case (funct3_q)
         3'b000:  load_ext_c = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
         3'b100:  load_ext_c = {24'd0, mem_rdata[7:0]};
         3'b001:  load_ext_c = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
         3'b101:  load_ext_c = {16'd0, mem_rdata[15:0]};
         default: load_ext_c = mem_rdata;
      endcase
   end

   // A reset edge must never commit a write, even mid-ACCESS
   assign mem_we = rst ? 4'b0000 : mem_we_q;

   // Control FSM with registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= 32'd0;
         mem_we_q   <= 4'b0000;
         mem_addr   <= '0;
         mem_wdata  <= 32'd0;
         we_q       <= 1'b0;
         funct3_q   <= 3'b000;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  we_q      <= req_we;
                  funct3_q  <= req_funct3;
                  req_ready <= 1'b0;
                  if (req_err_c) begin
                     // Rejected: straight to RESP, memory outputs untouched
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_rdata <= 32'd0;
                  end else begin
                     state     <= ACCESS;
                     mem_addr  <= req_addr[ADDR_W-1:0];
                     mem_wdata <= wdata_mask_c;
                     mem_we_q  <= req_we ? be_c : 4'b0000;
                  end
               end
            end
            ACCESS: begin
               state      <= RESP;
               mem_we_q   <= 4'b0000;
               resp_valid <= 1'b1;
               resp_err   <= 1'b0;
               resp_rdata <= we_q ? 32'd0 : load_ext_c;
            end
            RESP: begin
               if (resp_ready) begin
                  state      <= IDLE;
                  resp_valid <= 1'b0;
                  req_ready  <= 1'b1;
               end
            end
            default: begin
               state      <= IDLE;
               mem_we_q   <= 4'b0000;
               resp_valid <= 1'b0;
               req_ready  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_lsu.sv
// Testbench for mem_lsu: byte-array memory environment plus a byte-level
// reference memory; expected results are computed from access-size rules.
module tb_mem_lsu;

   localparam int unsigned ADDR_W = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [2:0]        req_funct3;
   logic [31:0]       req_addr;
   logic [31:0]       req_wdata;
   logic              resp_valid;
   logic              resp_ready;
   logic [31:0]       resp_rdata;
   logic              resp_err;
   logic [3:0]        mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] mem     [0:65535];
   logic [7:0] ref_mem [0:65535];

   // results of the last run_op
   int                lat;
   logic [31:0]       rd;
   logic              er;
   int                wc;
   logic [3:0]        ws;
   logic [31:0]       wds;
   logic [ADDR_W-1:0] was;
   logic              rdy;

   mem_lsu #(.ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // memory environment: combinational read, byte writes on rising edge
   assign mem_rdata = {mem[mem_addr + 16'd3], mem[mem_addr + 16'd2],
                       mem[mem_addr + 16'd1], mem[mem_addr]};

   always @(posedge clk) begin
      for (int i = 0; i < 4; i++)
         if (mem_we[i]) mem[mem_addr + 16'(i)] <= mem_wdata[8*i +: 8];
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic int nbytes(input logic [2:0] f3);
      return 1 << f3[1:0];
   endfunction

   function automatic bit exp_err(input logic [2:0] f3, input logic [31:0] a);
      if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b1;
      if (a >= 32'h0001_0000) return 1'b1;
      if (f3[1:0] == 2'b01 && (a % 2) != 0) return 1'b1;
      if (f3[1:0] == 2'b10 && (a % 4) != 0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a);
      logic [31:0] v;
      int n;
      n = nbytes(f3);
      v = 32'd0;
      for (int i = 0; i < n; i++)
         v = v | (32'(ref_mem[16'(a[15:0] + 16'(i))]) << (8*i));
      if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
      return v;
   endfunction

   function automatic logic [3:0] exp_be(input logic [2:0] f3);
      return 4'((1 << nbytes(f3)) - 1);
   endfunction

   function automatic logic [31:0] exp_wd(input logic [2:0] f3, input logic [31:0] wd);
      int n;
      n = nbytes(f3);
      if (n == 4) return wd;
      return wd & ((32'd1 << (8*n)) - 32'd1);
   endfunction

   task automatic apply_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
      for (int i = 0; i < nbytes(f3); i++)
         ref_mem[16'(a[15:0] + 16'(i))] = wd[8*i +: 8];
   endtask

   // ---------------- driver ----------------
   // Issues one request from IDLE, records latency (cycles after accept edge
   // until resp_valid), response values and any memory write activity.
   task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input bit release_resp);
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
      resp_ready = 1'b0;
      rdy = req_ready;
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = -1; wc = 0; ws = '0; wds = '0; was = '0; rd = '0; er = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (mem_we != 4'b0000) begin
            wc++; ws = mem_we; wds = mem_wdata; was = mem_addr;
         end
         if (resp_valid) begin
            lat = c;
            break;
         end
      end
      if (lat > 0) begin
         rd = resp_rdata;
         er = resp_err;
         if (release_resp) begin
            resp_ready = 1'b1;
            @(posedge clk);
            #1 resp_ready = 1'b0;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      @(negedge clk);
      vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL rst_req_ready: got %b expected 1", req_ready); end
      vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_resp_valid: got %b expected 0", resp_valid); end
      vectors++; if (resp_err !== 1'b0) begin miscompares++; $display("FAIL rst_resp_err: got %b expected 0", resp_err); end
      vectors++; if (resp_rdata !== 32'd0) begin miscompares++; $display("FAIL rst_resp_rdata: got %h expected 0", resp_rdata); end
      vectors++; if (mem_we !== 4'd0) begin miscompares++; $display("FAIL rst_mem_we: got %b expected 0000", mem_we); end
      vectors++; if (mem_addr !== '0) begin miscompares++; $display("FAIL rst_mem_addr: got %h expected 0", mem_addr); end
      vectors++; if (mem_wdata !== 32'd0) begin miscompares++; $display("FAIL rst_mem_wdata: got %h expected 0", mem_wdata); end
      rst = 1'b0;
   endtask

   task automatic test_word();
      run_op(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b1);
      vectors++; if (rdy !== 1'b1) begin miscompares++; $display("FAIL sw_ready: got %b expected 1", rdy); end
      vectors++; if (lat !== 2) begin miscompares++; $display("FAIL sw_latency: got %0d expected 2", lat); end
      vectors++; if (wc !== 1 || ws !== 4'b1111) begin miscompares++; $display("FAIL sw_we: got %0d cycles of %b expected 1 cycle of 1111", wc, ws); end
      vectors++; if (wds !== 32'hDEADBEEF || was !== 16'h0010) begin miscompares++; $display("FAIL sw_bus: got %h@%h expected deadbeef@0010", wds, was); end
      vectors++; if (er !== 1'b0 || rd !== 32'd0) begin miscompares++; $display("FAIL sw_resp: got err=%b rdata=%h expected 0/0", er, rd); end
      apply_store(3'b010, 32'h10, 32'hDEADBEEF);
      run_op(1'b0, 3'b010, 32'h10, 32'h0, 1'b1);
      vectors++; if (lat !== 2) begin miscompares++; $display("FAIL lw_latency: got %0d expected 2", lat); end
      vectors++; if (rd !== 32'hDEADBEEF || rd !== exp_load(3'b010, 32'h10)) begin miscompares++; $display("FAIL lw_rdata: got %h expected deadbeef", rd); end
      vectors++; if (er !== 1'b0 || wc !== 0) begin miscompares++; $display("FAIL lw_err_we: got err=%b we_cycles=%0d expected 0/0", er, wc); end
   endtask

   task automatic test_extension();
      logic [2:0]  f3s [4];
      logic [31:0] adr [4];
      logic [31:0] lit [4];
      f3s = '{3'b000, 3'b100, 3'b001, 3'b101};
      adr = '{32'h20, 32'h20, 32'h20, 32'h22};
      lit = '{32'hFFFFFF80, 32'h00000080, 32'hFFFFFF80, 32'h00001234};
      run_op(1'b1, 3'b010, 32'h20, 32'h1234FF80, 1'b1);
      apply_store(3'b010, 32'h20, 32'h1234FF80);
      for (int i = 0; i < 4; i++) begin
         run_op(1'b0, f3s[i], adr[i], 32'h0, 1'b1);
         vectors++;
         if (rd !== lit[i] || rd !== exp_load(f3s[i], adr[i]) || er !== 1'b0 || lat !== 2) begin
            miscompares++;
            $display("FAIL ext_load f3=%b @%h: got %h err=%b lat=%0d expected %h err=0 lat=2", f3s[i], adr[i], rd, er, lat, lit[i]);
         end
      end
   endtask

   task automatic test_partial();
      run_op(1'b1, 3'b010, 32'h30, 32'h11223344, 1'b1);
      apply_store(3'b010, 32'h30, 32'h11223344);
      run_op(1'b1, 3'b000, 32'h31, 32'h5566_77AB, 1'b1);
      vectors++; if (wc !== 1 || ws !== 4'b0001 || wds !== 32'h000000AB || was !== 16'h0031) begin
         miscompares++; $display("FAIL sb_bus: got we=%b x%0d wdata=%h addr=%h expected 0001 x1 000000ab 0031", ws, wc, wds, was); end
      apply_store(3'b000, 32'h31, 32'h556677AB);
      run_op(1'b0, 3'b010, 32'h30, 32'h0, 1'b1);
      vectors++; if (rd !== 32'h1122AB44 || rd !== exp_load(3'b010, 32'h30)) begin
         miscompares++; $display("FAIL partial_lw: got %h expected 1122ab44", rd); end
      // half store with upper bytes of wdata set
      run_op(1'b1, 3'b001, 32'h32, 32'hFFFF_BEEF, 1'b1);
      vectors++; if (ws !== 4'b0011 || wds !== 32'h0000BEEF) begin
         miscompares++; $display("FAIL sh_bus: got we=%b wdata=%h expected 0011 0000beef", ws, wds); end
      apply_store(3'b001, 32'h32, 32'hFFFFBEEF);
   endtask

   task automatic test_errors();
      logic        wes [6];
      logic [2:0]  f3s [6];
      logic [31:0] adr [6];
      wes = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      f3s = '{3'b001, 3'b010, 3'b011, 3'b010, 3'b111, 3'b101};
      adr = '{32'h1, 32'h2, 32'h10, 32'h0001_0000, 32'h10, 32'h43};
      for (int i = 0; i < 6; i++) begin
         run_op(wes[i], f3s[i], adr[i], 32'hA5A5A5A5, 1'b1);
         vectors++;
         if (er !== 1'b1 || rd !== 32'd0 || lat !== 1 || wc !== 0) begin
            miscompares++;
            $display("FAIL err_case%0d: got err=%b rdata=%h lat=%0d we_cycles=%0d expected 1/0/1/0", i, er, rd, lat, wc);
         end
      end
   endtask

   task automatic test_boundary();
      logic [2:0]  f3s [3];
      logic [31:0] adr [3];
      f3s = '{3'b010, 3'b001, 3'b000};
      adr = '{32'hFFFC, 32'hFFFE, 32'hFFFF};
      for (int i = 0; i < 3; i++) begin
         logic [31:0] d;
         d = $urandom;
         run_op(1'b1, f3s[i], adr[i], d, 1'b1);
         vectors++;
         if (er !== 1'b0 || lat !== 2 || ws !== exp_be(f3s[i]) || wds !== exp_wd(f3s[i], d)) begin
            miscompares++;
            $display("FAIL edge_store@%h: got err=%b lat=%0d we=%b wdata=%h", adr[i], er, lat, ws, wds);
         end
         apply_store(f3s[i], adr[i], d);
      end
      run_op(1'b0, 3'b010, 32'hFFFC, 32'h0, 1'b1);
      vectors++; if (rd !== exp_load(3'b010, 32'hFFFC)) begin
         miscompares++; $display("FAIL edge_lw: got %h expected %h", rd, exp_load(3'b010, 32'hFFFC)); end
   endtask

   task automatic test_random();
      // preload a window so every load there reads known bytes
      for (int w = 0; w < 16; w++) begin
         logic [31:0] d;
         d = $urandom;
         run_op(1'b1, 3'b010, 32'h100 + 32'(4*w), d, 1'b1);
         apply_store(3'b010, 32'h100 + 32'(4*w), d);
      end
      for (int k = 0; k < 60; k++) begin
         logic        we;
         logic [2:0]  f3;
         logic [31:0] a;
         logic [31:0] d;
         logic [31:0] expd;
         bit          e;
         we = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         d  = $urandom;
         case ($urandom_range(0, 9))
            0:       a = 32'h1_0000 + 32'($urandom_range(0, 255));
            1:       a = 32'hFFFC + 32'($urandom_range(0, 3));
            default: a = 32'h100 + 32'($urandom_range(0, 59));
         endcase
         e = exp_err(f3, a);
         expd = (e || we) ? 32'd0 : exp_load(f3, a);
         run_op(we, f3, a, d, 1'b1);
         vectors++;
         if (er !== e || rd !== expd || lat !== (e ? 1 : 2)) begin
            miscompares++;
            $display("FAIL rand%0d we=%b f3=%b @%h: got err=%b rdata=%h lat=%0d expected err=%b rdata=%h", k, we, f3, a, er, rd, lat, e, expd);
         end
         vectors++;
         if (we && !e) begin
            if (wc !== 1 || ws !== exp_be(f3) || wds !== exp_wd(f3, d) || was !== a[15:0]) begin
               miscompares++;
               $display("FAIL rand%0d_store: got we=%b x%0d wdata=%h addr=%h expected %b x1 %h %h", k, ws, wc, wds, was, exp_be(f3), exp_wd(f3, d), a[15:0]);
            end
            apply_store(f3, a, d);
         end else if (wc !== 0) begin
            miscompares++;
            $display("FAIL rand%0d_nowrite: got %0d write cycles expected 0", k, wc);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] d;
      logic [31:0] held;
      d = $urandom;
      run_op(1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
      held = rd;
      vectors++; if (held !== exp_load(3'b010, 32'h10) || lat !== 2) begin
         miscompares++; $display("FAIL bp_first: got %h lat=%0d expected %h lat=2", held, lat, exp_load(3'b010, 32'h10)); end
      // a waiting store must be ignored until IDLE
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h50; req_wdata = d;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         vectors++;
         if (resp_valid !== 1'b1 || resp_rdata !== held || resp_err !== 1'b0 || req_ready !== 1'b0 || mem_we !== 4'd0) begin
            miscompares++;
            $display("FAIL bp_hold%0d: got valid=%b rdata=%h err=%b ready=%b we=%b", k, resp_valid, resp_rdata, resp_err, req_ready, mem_we);
         end
      end
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
      @(negedge clk);
      vectors++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
         miscompares++; $display("FAIL bp_idle: got ready=%b valid=%b expected 1/0", req_ready, resp_valid); end
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      vectors++; if (mem_we !== 4'b1111 || mem_addr !== 16'h0050 || mem_wdata !== d) begin
         miscompares++; $display("FAIL bp_next_access: got we=%b addr=%h wdata=%h expected 1111 0050 %h", mem_we, mem_addr, mem_wdata, d); end
      @(negedge clk);
      vectors++; if (resp_valid !== 1'b1 || resp_err !== 1'b0) begin
         miscompares++; $display("FAIL bp_next_resp: got valid=%b err=%b expected 1/0", resp_valid, resp_err); end
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
      apply_store(3'b010, 32'h50, d);
      run_op(1'b0, 3'b010, 32'h50, 32'h0, 1'b1);
      vectors++; if (rd !== exp_load(3'b010, 32'h50)) begin
         miscompares++; $display("FAIL bp_readback: got %h expected %h", rd, exp_load(3'b010, 32'h50)); end
   endtask

   task automatic test_reset_midop();
      run_op(1'b1, 3'b010, 32'h40, 32'h0BAD_0BAD, 1'b1);
      apply_store(3'b010, 32'h40, 32'h0BAD0BAD);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h40; req_wdata = 32'hCAFEF00D;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      vectors++; if (mem_we !== 4'b1111) begin
         miscompares++; $display("FAIL rstmid_access: got we=%b expected 1111", mem_we); end
      rst = 1'b1;
      #1;
      vectors++; if (mem_we !== 4'b0000) begin
         miscompares++; $display("FAIL rstmid_we_forced: got %b expected 0000", mem_we); end
      @(negedge clk);
      vectors++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'd0 ||
          mem_we !== 4'd0 || mem_addr !== '0 || mem_wdata !== 32'd0) begin
         miscompares++;
         $display("FAIL rstmid_outputs: got ready=%b valid=%b err=%b rdata=%h we=%b addr=%h wdata=%h", req_ready, resp_valid, resp_err, resp_rdata, mem_we, mem_addr, mem_wdata);
      end
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         vectors++; if (resp_valid !== 1'b0) begin
            miscompares++; $display("FAIL rstmid_no_resp%0d: got valid=%b expected 0", k, resp_valid); end
      end
      run_op(1'b0, 3'b010, 32'h40, 32'h0, 1'b1);
      vectors++; if (rd !== 32'h0BAD0BAD || rd !== exp_load(3'b010, 32'h40)) begin
         miscompares++; $display("FAIL rstmid_mem: got %h expected 0bad0bad", rd); end
   endtask

   task automatic test_reset_resp();
      run_op(1'b0, 3'b010, 32'h30, 32'h0, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      vectors++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
         miscompares++; $display("FAIL rstresp: got valid=%b ready=%b expected 0/1", resp_valid, req_ready); end
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
      req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0;
      repeat (3) @(posedge clk);
      test_reset();
      test_word();
      test_extension();
      test_partial();
      test_errors();
      test_boundary();
      test_random();
      test_backpressure();
      test_reset_midop();
      test_reset_resp();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Load/store requester for the byte-addressed data memory: accepts one CPU load or store at a time over a valid/ready handshake and drives the memory's byte write enables, address and write data. For loads, it captures the memory's combinational read data and returns a sign- or zero-extended result. It sits between the single-cycle datapath's execute stage and the data memory, and flags misaligned, out-of-range or illegal-size requests without touching memory.

## Interface
- ADDR_W, 16, memory address width; addresses at or above 2^ADDR_W are out of range
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  LSU can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  size: 000 B, 001 H, 010 W, 100 BU, 101 HU; others illegal
- req_addr  in  32  byte address
- req_wdata  in  32  store data, low-aligned
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  request rejected, no memory access performed
- mem_we  out  4  byte write enables; bit i writes byte addr+i
- mem_addr  out  ADDR_W  memory byte address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  combinational read: {m[a+3],m[a+2],m[a+1],m[a]}

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: req_ready=1. When req_valid is high, latch we, funct3, addr, wdata.
  - If the request is legal, go to ACCESS.
  - Otherwise go to RESP with err=1.
- Error conditions, checked in this order, any one sufficient:
  - funct3 in {011,110,111};
  - req_addr[31:ADDR_W] != 0;
  - H/HU with addr[0] != 0;
  - W with addr[1:0] != 0.
- Store B, H or W with addr = 0xFFFF, 0xFFFE or 0xFFFC passes the checks; memory index wrap is memory's concern.
- ACCESS (exactly one cycle): mem_addr = latched addr[ADDR_W-1:0].
  - Store: mem_we = 0001 (B), 0011 (H), 1111 (W). mem_wdata = latched wdata, with bytes above the size zeroed.
  - Load: mem_we = 0000. At the end of the cycle, capture the extended mem_rdata into the response register:
    - B sign-extends [7:0]; BU zero-extends [7:0];
    - H sign-extends [15:0]; HU zero-extends [15:0];
    - W takes [31:0].
  - Go to RESP.
- RESP: resp_valid=1; resp_rdata and resp_err are held stable until resp_ready. When resp_ready is high, go to IDLE.
- mem_we is 0000 in every state except ACCESS-store. It is also combinationally forced to 0000 whenever rst=1, so no write commits on a reset edge.
- mem_addr and mem_wdata hold their last latched values outside ACCESS.

## Timing
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Legal request accepted at edge N:
  - ACCESS during cycle N+1; the store byte write lands at edge N+2;
  - resp_valid high from cycle N+2.
- Illegal request accepted at edge N: resp_valid from cycle N+1, with no ACCESS cycle.
- resp_valid and resp_ready both high at edge M: IDLE in cycle M+1, so the next request is accepted no earlier than edge M+1.
  - Minimum legal throughput: one op per 3 cycles.
- req_valid while not in IDLE is ignored; the requester must hold it.
- rst during ACCESS (store): no bytes written; state returns to IDLE; no response is issued.
- rst during RESP: the response is dropped; resp_valid=0 next cycle.
- resp_ready high while in IDLE or ACCESS has no effect.

## Test plan
- Word store/load: SW 0xDEADBEEF @0x0010, then LW @0x0010.
  - Store: mem_we=1111 for exactly one cycle.
  - Load: resp_rdata=0xDEADBEEF, resp_err=0, resp_valid 2 cycles after accept.
- Byte/half extension: memory 0x0020..23 = 80 FF 34 12.
  - LB @0x20 -> 0xFFFFFF80; LBU @0x20 -> 0x00000080.
  - LH @0x20 -> 0xFFFFFF80; LHU @0x22 -> 0x00001234.
- Partial store: word 0x11223344 @0x30, then SB 0xAB @0x31 (mem_we=0001, mem_wdata=0x000000AB). LW @0x30 -> 0x1122AB44.
- Errors:
  - LH @0x0001, SW @0x0002, funct3=011 and LW @0x00010000 each give resp_err=1 and rdata=0.
  - resp_valid appears 1 cycle after accept; mem_we stays 0000 throughout.
- Backpressure: hold resp_ready=0 for 5 cycles after an LW. resp_valid and rdata stay stable and req_ready=0. Raise resp_ready: IDLE next cycle, next request accepted on the following edge.
- Reset mid-op: SW 0xCAFEF00D @0x40 with rst asserted during ACCESS. The memory word is unchanged, no response is issued, and all outputs match their reset values the next cycle.
